// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// alu_op_sequencer : decodes ALU requests, holds the ALU buses for settling,
//                    then returns the captured BusW/Zero on a response.  Rev 1.0
// ============================================================================
module alu_op_sequencer #(
  parameter int n           = 64,
  parameter int WAIT_CYCLES = 3
) (
  input  logic         CLK,
  input  logic         Reset_L,
  input  logic         ReqValid,
  output logic         ReqReady,
  input  logic [1:0]   ReqALUOp,
  input  logic [10:0]  ReqOpcode,
  input  logic [n-1:0] ReqA,
  input  logic [n-1:0] ReqB,
  output logic [3:0]   AluCtrl,
  output logic [n-1:0] AluA,
  output logic [n-1:0] AluB,
  input  logic [n-1:0] AluW,
  input  logic         AluZero,
  output logic         RespValid,
  input  logic         RespReady,
  output logic [n-1:0] RespW,
  output logic         RespZero,
  output logic         RespErr
);

  localparam int         CNT_W       = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_wait_init = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  localparam logic [3:0]  c_ctrl_and  = 4'b0000;
  localparam logic [3:0]  c_ctrl_orr  = 4'b0001;
  localparam logic [3:0]  c_ctrl_add  = 4'b0010;
  localparam logic [3:0]  c_ctrl_sub  = 4'b0110;
  localparam logic [3:0]  c_ctrl_passb = 4'b0111;

  localparam logic [10:0] c_opc_add = 11'b10001011000;
  localparam logic [10:0] c_opc_sub = 11'b11001011000;
  localparam logic [10:0] c_opc_and = 11'b10001010000;
  localparam logic [10:0] c_opc_orr = 11'b10101010000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic [n-1:0]     alu_a_q, alu_a_d;
  logic [n-1:0]     alu_b_q, alu_b_d;
  logic             resp_valid_q, resp_valid_d;
  logic [n-1:0]     resp_w_q, resp_w_d;
  logic             resp_zero_q, resp_zero_d;
  logic             resp_err_q, resp_err_d;

  logic [3:0]       dec_ctrl;
  logic             dec_legal;

  always_comb begin
    dec_ctrl  = c_ctrl_add;
    dec_legal = 1'b1;
    unique case (ReqALUOp)
      2'b00: dec_ctrl = c_ctrl_add;
      2'b01: dec_ctrl = c_ctrl_passb;
      2'b10: begin
        unique case (ReqOpcode)
          c_opc_add: dec_ctrl = c_ctrl_add;
          c_opc_sub: dec_ctrl = c_ctrl_sub;
          c_opc_and: dec_ctrl = c_ctrl_and;
          c_opc_orr: dec_ctrl = c_ctrl_orr;
          default:   dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    resp_valid_d = resp_valid_q;
    resp_w_d     = resp_w_q;
    resp_zero_d  = resp_zero_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      S_IDLE: begin
        if (ReqValid) begin
          if (dec_legal) begin
            alu_ctrl_d = dec_ctrl;
            alu_a_d    = ReqA;
            alu_b_d    = ReqB;
            cnt_d      = c_wait_init;
            state_d    = S_WAIT;
          end else begin
            // Undecodable request skips the ALU entirely and answers at once.
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_w_d     = '0;
            resp_zero_d  = 1'b0;
            state_d      = S_RESP;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - c_cnt_one;
        if (cnt_q == c_cnt_one) begin
          resp_w_d     = AluW;
          resp_zero_d  = AluZero;
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (RespReady) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      alu_ctrl_q   <= 4'b0000;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_w_q     <= '0;
      resp_zero_q  <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      resp_valid_q <= resp_valid_d;
      resp_w_q     <= resp_w_d;
      resp_zero_q  <= resp_zero_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign ReqReady  = (state_q == S_IDLE);
  assign AluCtrl   = alu_ctrl_q;
  assign AluA      = alu_a_q;
  assign AluB      = alu_b_q;
  assign RespValid = resp_valid_q;
  assign RespW     = resp_w_q;
  assign RespZero  = resp_zero_q;
  assign RespErr   = resp_err_q;

endmodule
`default_nettype wire
